// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of the shared combinational ALU, with
// bounded ownership locks and a one-cycle registered response path.
module alu_arbiter #(
    parameter int              W        = 8,
    parameter int              OPS      = 4,
    parameter logic [OPS-1:0]  IDLE_OP  = '0,
    parameter int              MAX_LOCK = 4
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            req0,
    input  logic            req1,
    input  logic            lock0,
    input  logic            lock1,
    input  logic [OPS-1:0]  op0,
    input  logic [OPS-1:0]  op1,
    input  logic [W-1:0]    a0,
    input  logic [W-1:0]    a1,
    input  logic [W-1:0]    b0,
    input  logic [W-1:0]    b1,
    input  logic [2:0]      loop0,
    input  logic [2:0]      loop1,
    input  logic [4:0]      imm0,
    input  logic [4:0]      imm1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [OPS-1:0]  alu_op,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [2:0]      alu_loop,
    output logic [4:0]      alu_imm,
    input  logic [W-1:0]    alu_out,
    input  logic            alu_zero,
    input  logic            alu_parity,
    input  logic            alu_odd,
    output logic            rsp_valid0,
    output logic            rsp_valid1,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_zero,
    output logic            rsp_parity,
    output logic            rsp_odd,
    output logic            locked
);

    localparam int              LCW      = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0]  LOCK_MAX = LCW'(MAX_LOCK);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;

    logic            rsp_valid0_q, rsp_valid0_d;
    logic            rsp_valid1_q, rsp_valid1_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_parity_q, rsp_parity_d;
    logic            rsp_odd_q, rsp_odd_d;

    logic            gnt0_c, gnt1_c;
    logic            free_arb;

    // An owner whose req is low falls back to ordinary round-robin arbitration.
    always_comb begin
        gnt0_c   = 1'b0;
        gnt1_c   = 1'b0;
        free_arb = 1'b1;
        case (state_q)
            OWN0: begin
                if (req0) begin
                    free_arb = 1'b0;
                    if ((lock_cnt_q >= LOCK_MAX) && req1) gnt1_c = 1'b1;
                    else                                  gnt0_c = 1'b1;
                end
            end
            OWN1: begin
                if (req1) begin
                    free_arb = 1'b0;
                    if ((lock_cnt_q >= LOCK_MAX) && req0) gnt0_c = 1'b1;
                    else                                  gnt1_c = 1'b1;
                end
            end
            default: ;
        endcase
        if (free_arb) begin
            if (req0 && req1) begin
                gnt0_c = last_gnt_q;
                gnt1_c = ~last_gnt_q;
            end else begin
                gnt0_c = req0;
                gnt1_c = req1;
            end
        end
    end

    always_comb begin
        alu_op   = IDLE_OP;
        alu_a    = '0;
        alu_b    = '0;
        alu_loop = '0;
        alu_imm  = '0;
        if (gnt0_c) begin
            alu_op   = op0;
            alu_a    = a0;
            alu_b    = b0;
            alu_loop = loop0;
            alu_imm  = imm0;
        end else if (gnt1_c) begin
            alu_op   = op1;
            alu_a    = a1;
            alu_b    = b1;
            alu_loop = loop1;
            alu_imm  = imm1;
        end
    end

    always_comb begin
        state_d    = FREE;
        lock_cnt_d = '0;
        last_gnt_d = last_gnt_q;
        if (gnt0_c) begin
            last_gnt_d = 1'b0;
            if (lock0) begin
                state_d = OWN0;
                if (state_q == OWN0)
                    lock_cnt_d = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 1'b1;
                else
                    lock_cnt_d = LCW'(1);
            end
        end else if (gnt1_c) begin
            last_gnt_d = 1'b1;
            if (lock1) begin
                state_d = OWN1;
                if (state_q == OWN1)
                    lock_cnt_d = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 1'b1;
                else
                    lock_cnt_d = LCW'(1);
            end
        end
    end

    // Response registers only load on a granted cycle so the last result persists.
    always_comb begin
        rsp_valid0_d = gnt0_c;
        rsp_valid1_d = gnt1_c;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_parity_d = rsp_parity_q;
        rsp_odd_d    = rsp_odd_q;
        if (gnt0_c || gnt1_c) begin
            rsp_data_d   = alu_out;
            rsp_zero_d   = alu_zero;
            rsp_parity_d = alu_parity;
            rsp_odd_d    = alu_odd;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= FREE;
            last_gnt_q   <= 1'b1;
            lock_cnt_q   <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_parity_q <= 1'b0;
            rsp_odd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            lock_cnt_q   <= lock_cnt_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_parity_q <= rsp_parity_d;
            rsp_odd_q    <= rsp_odd_d;
        end
    end

    assign gnt0       = gnt0_c;
    assign gnt1       = gnt1_c;
    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_parity = rsp_parity_q;
    assign rsp_odd    = rsp_odd_q;
    assign locked     = (state_q != FREE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// every cycle against an ownership/run-length reference model.
module tb_alu_arbiter;

    localparam int          W        = 8;
    localparam int          OPS      = 4;
    localparam int          MAX_LOCK = 4;
    localparam logic [3:0]  IDLE_OP  = 4'd0;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        req[2];
    logic        lock[2];
    logic [3:0]  op[2];
    logic [7:0]  a[2];
    logic [7:0]  b[2];
    logic [2:0]  loopv[2];
    logic [4:0]  imm[2];

    logic        gnt0, gnt1;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_loop;
    logic [4:0]  alu_imm;
    logic [7:0]  alu_out;
    logic        alu_zero, alu_parity, alu_odd;
    logic        rsp_valid0, rsp_valid1;
    logic [7:0]  rsp_data;
    logic        rsp_zero, rsp_parity, rsp_odd;
    logic        locked;

    int checks = 0;
    int failures = 0;

    // reference model: who owns the ALU and how long the current locked run is
    int          owner;
    int          run;
    int          last;
    int          eg;
    logic        ev[2];
    logic [7:0]  ed;
    logic        ez, ep, eo;

    alu_arbiter #(.W(W), .OPS(OPS), .IDLE_OP(IDLE_OP), .MAX_LOCK(MAX_LOCK)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0(req[0]), .req1(req[1]), .lock0(lock[0]), .lock1(lock[1]),
        .op0(op[0]), .op1(op[1]), .a0(a[0]), .a1(a[1]), .b0(b[0]), .b1(b[1]),
        .loop0(loopv[0]), .loop1(loopv[1]), .imm0(imm[0]), .imm1(imm[1]),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_loop(alu_loop), .alu_imm(alu_imm),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_odd(alu_odd),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_parity(rsp_parity), .rsp_odd(rsp_odd),
        .locked(locked)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] alu_fn(input logic [3:0] o, input logic [7:0] x,
                                          input logic [7:0] y, input logic [2:0] l,
                                          input logic [4:0] im);
        case (o)
            4'd0:    return 8'(x + y + {5'b0, l});
            4'd1:    return 8'(x - y);
            4'd2:    return x & y;
            4'd3:    return x ^ y;
            4'd4:    return x | y;
            4'd5:    return 8'(x + {3'b0, im});
            default: return ~x;
        endcase
    endfunction

    // stand-in ALU driven from the arbiter's mux outputs
    always_comb begin
        alu_out    = alu_fn(alu_op, alu_a, alu_b, alu_loop, alu_imm);
        alu_zero   = (alu_out == 8'd0);
        alu_parity = ^alu_out;
        alu_odd    = alu_out[0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        run   = 0;
        last  = 1;
        eg    = -1;
        ev[0] = 1'b0;
        ev[1] = 1'b0;
        ed    = 8'd0;
        ez    = 1'b0;
        ep    = 1'b0;
        eo    = 1'b0;
    endtask

    function automatic int exp_grant();
        int oth;
        if (owner >= 0 && req[owner]) begin
            oth = 1 - owner;
            if (run >= MAX_LOCK && req[oth]) return oth;
            return owner;
        end
        if (req[0] && req[1]) return 1 - last;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        ev[0] = 1'b0;
        ev[1] = 1'b0;
        eg    = g;
        if (g < 0) begin
            owner = -1;
            run   = 0;
        end else begin
            last  = g;
            ev[g] = 1'b1;
            ed    = alu_fn(op[g], a[g], b[g], loopv[g], imm[g]);
            ez    = (ed == 8'd0);
            ep    = ^ed;
            eo    = ed[0];
            if (!lock[g]) begin
                owner = -1;
                run   = 0;
            end else if (owner == g) begin
                run = (run < MAX_LOCK) ? run + 1 : MAX_LOCK;
            end else begin
                owner = g;
                run   = 1;
            end
        end
    endtask

    // inputs are set at posedge+1; checks at negedge; model advances at posedge
    task automatic step();
        int g;
        logic [3:0] e_op;
        logic [7:0] e_a, e_b;
        logic [2:0] e_l;
        logic [4:0] e_i;
        @(negedge Clk);
        g = exp_grant();
        e_op = IDLE_OP; e_a = 8'd0; e_b = 8'd0; e_l = 3'd0; e_i = 5'd0;
        if (g >= 0) begin
            e_op = op[g]; e_a = a[g]; e_b = b[g]; e_l = loopv[g]; e_i = imm[g];
        end
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        chk("alu_op", 32'(alu_op), 32'(e_op));
        chk("alu_a", 32'(alu_a), 32'(e_a));
        chk("alu_b", 32'(alu_b), 32'(e_b));
        chk("alu_loop", 32'(alu_loop), 32'(e_l));
        chk("alu_imm", 32'(alu_imm), 32'(e_i));
        chk("locked", 32'(locked), 32'(owner >= 0));
        chk("rsp_valid0", 32'(rsp_valid0), 32'(ev[0]));
        chk("rsp_valid1", 32'(rsp_valid1), 32'(ev[1]));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_zero", 32'(rsp_zero), 32'(ez));
        chk("rsp_parity", 32'(rsp_parity), 32'(ep));
        chk("rsp_odd", 32'(rsp_odd), 32'(eo));
        @(posedge Clk);
        model_update(g);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic l, input logic [3:0] o,
                            input logic [7:0] x, input logic [7:0] y, input logic [2:0] lp,
                            input logic [4:0] im);
        req[p] = r; lock[p] = l; op[p] = o; a[p] = x; b[p] = y; loopv[p] = lp; imm[p] = im;
    endtask

    initial begin
        set_port(0, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 3'd0, 5'd0);
        set_port(1, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 3'd0, 5'd0);
        model_reset();
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_valid0", 32'(rsp_valid0), 32'd0);
        chk("rst_valid1", 32'(rsp_valid1), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_flags", 32'({rsp_zero, rsp_parity, rsp_odd}), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // single ADD from port 0: 0x10 + loop 3 -> 0x13
        set_port(0, 1'b1, 1'b0, 4'd0, 8'h10, 8'h00, 3'd3, 5'd0);
        step();
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 5'd0);
        step();
        chk("t1_rsp_data", 32'(ed), 32'h13);

        // contention without locks alternates every cycle
        set_port(0, 1'b1, 1'b0, 4'd1, 8'h55, 8'h11, 3'd0, 5'd0);
        set_port(1, 1'b1, 1'b0, 4'd2, 8'hF3, 8'h3C, 3'd0, 5'd0);
        repeat (4) step();

        // port 1 locked with port 0 contending: forced break after MAX_LOCK grants
        set_port(0, 1'b0, 1'b0, 4'd4, 8'h01, 8'h02, 3'd0, 5'd0);
        set_port(1, 1'b1, 1'b1, 4'd5, 8'h20, 8'h00, 3'd0, 5'd7);
        step();
        req[0] = 1'b1;
        repeat (MAX_LOCK) step();
        set_port(1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 5'd0);
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 5'd0);
        repeat (3) step();

        // port 0 locked, then drops while port 1 requests XOR
        set_port(0, 1'b1, 1'b1, 4'd0, 8'h01, 8'h01, 3'd0, 5'd0);
        step();
        req[0] = 1'b0;
        set_port(1, 1'b1, 1'b0, 4'd3, 8'hF0, 8'h0F, 3'd0, 5'd0);
        step();
        req[1] = 1'b0;
        step();
        chk("xor_data", 32'(ed), 32'hFF);

        // async reset in the middle of a locked sequence
        set_port(0, 1'b1, 1'b1, 4'd0, 8'h07, 8'h01, 3'd1, 5'd0);
        step();
        step();
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_valid0", 32'(rsp_valid0), 32'd0);
        chk("mid_rst_data", 32'(rsp_data), 32'd0);
        req[0] = 1'b0;
        lock[0] = 1'b0;
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        set_port(0, 1'b1, 1'b0, 4'd1, 8'h09, 8'h09, 3'd0, 5'd0);
        set_port(1, 1'b1, 1'b0, 4'd4, 8'h80, 8'h01, 3'd0, 5'd0);
        step();
        chk("tie_after_rst", 32'(eg), 32'd0);

        // randomized traffic; ungranted requesters hold their inputs
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req[p] && eg != p)) begin
                    set_port(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                             4'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 5'($urandom));
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the instruction execute stage, port 1 is the loop/address-update unit.
- Grants at most one request per cycle, using round-robin arbitration with an optional lock for multi-op sequences.
- Drives the ALU operand and opcode inputs.
- Registers the ALU result and flags, and returns them to the granted requester one cycle later.

Parameters:
- W, 8, data width of operands and result.
- OPS, 4, opcode width; matches the ALU OP field.
- IDLE_OP, 0, opcode driven to the ALU when there is no grant (ADD; operands are forced to 0).
- MAX_LOCK, 4, maximum consecutive locked grants before a contending requester is forced in.

Ports:
- Clk  in  1  clock.
- Reset_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request valid, per requester.
- lock0, lock1  in  1  keep ownership after this grant; sampled only when the same requester's req is high.
- op0, op1  in  OPS  requested ALU opcode.
- a0, a1, b0, b1  in  W  operands A and B.
- loop0, loop1  in  3  3-bit immediate.
- imm0, imm1  in  5  5-bit immediate.
- gnt0, gnt1  out  1  combinational grant in the same cycle; one-hot or zero.
- alu_op  out  OPS  to the ALU OP input.
- alu_a, alu_b  out  W  to the ALU InputA/InputB inputs.
- alu_loop  out  3  to the ALU Loop input.
- alu_imm  out  5  to the ALU Immediate input.
- alu_out  in  W  ALU result.
- alu_zero, alu_parity, alu_odd  in  1  ALU flags.
- rsp_valid0, rsp_valid1  out  1  registered; result is valid for that requester.
- rsp_data  out  W  registered result.
- rsp_zero, rsp_parity, rsp_odd  out  1  registered flags.
- locked  out  1  an ownership lock is active.

Behaviour:
- State: {FREE, OWN0, OWN1}, plus last_gnt (1 bit) and lock_cnt (clog2(MAX_LOCK+1) bits).
- Reset (async, Reset_n=0):
  - State=FREE, last_gnt=1 (so port 0 wins the first tie), lock_cnt=0.
  - All rsp_* = 0, locked = 0.
- Grant logic, all combinational from state and requests:
  - FREE: only one req high -> grant it. Both high -> grant the port != last_gnt.
  - OWNx with reqx=1, and either lock_cnt<MAX_LOCK or the other req=0 -> grant x.
  - OWNx with reqx=0 -> behave as FREE.
  - OWNx with lock_cnt==MAX_LOCK and the other req=1 -> grant the other port (forced break).
- ALU mux:
  - Granted port's op/a/b/loop/imm appear on the alu_* outputs in the same cycle.
  - No grant -> alu_op=IDLE_OP; alu_a, alu_b, alu_loop, alu_imm = 0. The ALU must never see X from an idle requester.
- State update (posedge Clk), on a grant to port g:
  - last_gnt <= g.
  - lockg=1 and state already OWNg -> state stays OWNg, lock_cnt <= lock_cnt+1, saturating at MAX_LOCK.
  - lockg=1 and state != OWNg -> state <= OWNg, lock_cnt <= 1.
  - lockg=0 -> state <= FREE, lock_cnt <= 0.
- State update, no grant: state <= FREE, lock_cnt <= 0.
- Forced break: the port granted by force gets a normal grant and may itself lock. The previous owner loses the lock; state follows the rule above for the new grantee.
- Response, latency 1:
  - rsp_validg <= 1 on the cycle after gntg; otherwise 0.
  - rsp_data and the flags capture alu_out/alu_zero/alu_parity/alu_odd on every granted cycle.
  - They hold their previous value when there is no grant.
- locked = (state != FREE).
- Back-to-back grants to alternating ports are allowed every cycle; there are no bubbles.
- Reset asserted mid-sequence:
  - Lock is dropped and rsp_valid* clears immediately.
  - The in-flight result is lost; requesters must re-issue.
- Requesters hold their inputs stable while req is high and not granted. The arbiter does not buffer ungranted requests.

Test Plan:
- Reset, then req0=1 only, op=ADD, a0=8'h10, loop0=3 -> gnt0=1 in the same cycle, alu_a=8'h10; next cycle rsp_valid0=1, rsp_data=8'h13, rsp_zero=0.
- req0=req1=1 held for 4 cycles, lock=0 -> grants alternate 0,1,0,1. rsp_valid0/rsp_valid1 alternate one cycle later. gnt0&gnt1 is never 1.
- req1=1, lock1=1 held, req0=1 from cycle 2, MAX_LOCK=4 -> port 1 granted for 4 consecutive cycles with locked=1, then gnt0=1 on the 5th cycle.
- Idle (req0=req1=0) -> alu_op=IDLE_OP, alu_a=alu_b=0, rsp_valid*=0, rsp_data holds its last value (e.g. 8'h13).
- Port 0 locked for 2 cycles, then Reset_n pulsed low asynchronously between clock edges -> locked=0 and rsp_valid0=0 immediately. After release, tie-break favours port 0.
- Port 0 locked, then req0 drops with req1=1 -> gnt1=1 in that same cycle and state returns to FREE or OWN1 per lock1. XOR of a1=8'hF0, b1=8'h0F -> rsp_data=8'hFF, rsp_parity=0.
